stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
Control sequencer for the centisecond/second/minute stopwatch timer datapath. It debounces two push-buttons and runs a start/stop/lap/reset state machine. It drives the timer's run-enable and synchronous clear, and freezes a lap snapshot for the 7-segment display path. It sits between the board button inputs and the timer and display blocks.

Parameters:
DEB_CYCLES, 1000000, consecutive stable cycles required to accept a button level change (10 ms at 100 MHz)
DEB_W, 20, debounce counter width; must satisfy 2^DEB_W >= DEB_CYCLES

Ports:
clk  in  1  system clock; the only clock
rst  in  1  reset, synchronous, active-high
btn_ss  in  1  raw start/stop button, active-high, asynchronous and bouncy
btn_lr  in  1  raw lap/reset button, active-high, asynchronous and bouncy
ms  in  7  timer centiseconds, 0..99
sec  in  7  timer seconds, 0..59
min  in  7  timer minutes, 0..59
tick_s  in  1  timer pulse on the centisecond 99->0 rollover, already gated by run_en
run_en  out  1  timer count enable
clr  out  1  one-cycle synchronous clear to the timer
disp_ms  out  7  displayed centiseconds
disp_sec  out  7  displayed seconds
disp_min  out  7  displayed minutes
lap_active  out  1  high while the display is frozen on a lap
ovf  out  1  sticky flag: timer wrapped past 59:59.99

Behaviour:
- Reset: when rst is sampled high at a clk edge, all outputs go to 0, the state goes to IDLE, the synchronisers and debounced levels go to 0, and the debounce counters go to 0. Reset overrides any operation in progress, including a pending clr.
- Input synchronisation: each button passes through a 2-flop synchroniser (s2).
- Debounce, per button:
  - If s2 equals the debounced level, the counter is set to 0.
  - Otherwise the counter increments. When the counter equals DEB_CYCLES-1, the debounced level takes s2 and the counter is set to 0.
  - A glitch shorter than DEB_CYCLES cycles is ignored.
- Press event: a one-cycle pulse (ev_ss, ev_lr) on each 0->1 change of the debounced level. A release generates no event.
- Priority: if ev_ss and ev_lr occur in the same cycle, ev_ss is processed and ev_lr is dropped.
- FSM, registered. The state updates on the edge where the event is high; outputs follow from the registered state.
  - IDLE: run_en=0.
    - ev_ss -> RUN.
    - ev_lr -> clr pulse, stay in IDLE.
  - RUN: run_en=1.
    - ev_ss -> PAUSE.
    - ev_lr -> LAP and capture the lap snapshot.
  - LAP: run_en=1, lap_active=1.
    - ev_ss -> PAUSE. The freeze is released.
    - ev_lr -> RUN. The freeze is released.
  - PAUSE: run_en=0.
    - ev_ss -> RUN.
    - ev_lr -> clr pulse, go to IDLE.
- clr:
  - Asserted for exactly one cycle, in the cycle after the ev_lr that caused it.
  - Never asserted while run_en=1.
  - Also clears ovf in the same cycle.
- Display:
  - In every state except LAP, disp_* is a register loaded each cycle from ms/sec/min, giving one cycle of latency.
  - On the RUN->LAP edge, disp_* is loaded with the current ms/sec/min and then held for the whole of LAP.
  - On leaving LAP, disp_* resumes live tracking from the next edge.
- ovf:
  - Set when run_en && tick_s && sec==59 && min==59, i.e. the timer wraps to 00:00.00.
  - Held until clr or rst.
  - If a set condition and clr occur in the same cycle, clr wins.
- Latency from the first stable raw level:
  - 2 synchroniser cycles, plus DEB_CYCLES debounce cycles, plus 1 cycle for the event, plus 1 cycle for the state/run_en change.
- Buttons held down: a held button generates exactly one event. A new event requires a debounced release and then a new press.

Test Plan:
All scenarios use DEB_CYCLES=4 and DEB_W=3.
- Reset: hold rst high for 3 cycles with both buttons high -> all outputs 0 and state IDLE; after rst falls, 1 ev_ss occurs when the debounce expires, then RUN.
- Bounce rejection: toggle btn_ss with high/low pulses of 1, 2, then 3 cycles, followed by 10 cycles high -> exactly one ev_ss; run_en rises 2+4+1+1 = 8 cycles after the final 0->1 transition.
- Lap freeze:
  - Stimulus: in RUN, drive ms/sec/min = 42/17/3 in the ev_lr cycle, then advance the inputs.
  - Required: disp shows 42/17/3 and lap_active=1 until the next ev_lr; after that ev_lr, disp tracks the live inputs with 1 cycle of latency.
- Pause/clear: the sequence RUN, ev_ss, then ev_lr -> run_en falls, then clr=1 for exactly one cycle, then IDLE. An ev_lr in RUN never produces clr.
- Simultaneous press: ev_ss and ev_lr in the same cycle in RUN -> PAUSE, with no lap capture and lap_active=0.
- Overflow: in RUN, drive sec=59, min=59 and pulse tick_s -> ovf=1 and stays 1 through PAUSE; on the clr cycle ovf=0; a tick_s arriving in the same cycle as clr leaves ovf=0.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer.
// Synchronises and debounces the start/stop and lap/reset buttons, turns
// debounced presses into one-cycle events, and runs the IDLE/RUN/LAP/PAUSE
// machine. It drives the timer enable/clear, the lap-frozen display copy and
// the sticky overflow flag.
module stopwatch_ctrl #(
  parameter int DEB_CYCLES = 1000000,
  parameter int DEB_W      = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ss,
  input  logic       btn_lr,
  input  logic [6:0] ms,
  input  logic [6:0] sec,
  input  logic [6:0] min,
  input  logic       tick_s,
  output logic       run_en,
  output logic       clr,
  output logic [6:0] disp_ms,
  output logic [6:0] disp_sec,
  output logic [6:0] disp_min,
  output logic       lap_active,
  output logic       ovf
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_LAP   = 2'd2,
    ST_PAUSE = 2'd3
  } state_t;

  // Counter value at which a changed level has been stable long enough.
  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES - 1);
  localparam logic [DEB_W-1:0] CNT_ZERO = {DEB_W{1'b0}};
  localparam logic [DEB_W-1:0] CNT_ONE  = {{(DEB_W-1){1'b0}}, 1'b1};

  // Bit 0 is the start/stop button, bit 1 the lap/reset button.
  logic [1:0]       sync_meta_r;
  logic [1:0]       sync_s2_r;
  logic [1:0]       deb_r;
  logic [1:0]       deb_d_r;
  logic [1:0]       ev_r;
  logic [DEB_W-1:0] cnt_r [2];

  logic   ev_ss_s;
  logic   ev_lr_s;
  logic   ovf_set_s;
  state_t state_r;

  // Two-flop synchroniser for the asynchronous raw buttons.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta_r <= 2'b00;
      sync_s2_r   <= 2'b00;
    end else begin
      sync_meta_r <= {btn_lr, btn_ss};
      sync_s2_r   <= sync_meta_r;
    end
  end

  // Debounce: accept a new level only after it has differed for DEB_CYCLES cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_r <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_s2_r[i] == deb_r[i]) begin
          cnt_r[i] <= CNT_ZERO;
        end else if (cnt_r[i] == DEB_MAX) begin
          deb_r[i] <= sync_s2_r[i];
          cnt_r[i] <= CNT_ZERO;
        end else begin
          cnt_r[i] <= cnt_r[i] + CNT_ONE;
        end
      end
    end
  end

  // Rising-edge detect on the debounced levels: one registered pulse per press.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_d_r <= 2'b00;
      ev_r    <= 2'b00;
    end else begin
      deb_d_r <= deb_r;
      ev_r    <= deb_r & ~deb_d_r;
    end
  end

  // Event decode and overflow set condition (start/stop wins over lap/reset).
  always_comb begin
    ev_ss_s   = 1'b0;
    ev_lr_s   = 1'b0;
    ovf_set_s = 1'b0;
    if (ev_r[0]) begin
      ev_ss_s = 1'b1;
    end else begin
      ev_lr_s = ev_r[1];
    end
    if (run_en && tick_s && (sec == 7'd59) && (min == 7'd59)) begin
      ovf_set_s = 1'b1;
    end else begin
      ovf_set_s = 1'b0;
    end
  end

  // Control state machine with registered outputs, display copy and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      run_en     <= 1'b0;
      clr        <= 1'b0;
      lap_active <= 1'b0;
      ovf        <= 1'b0;
      disp_ms    <= 7'd0;
      disp_sec   <= 7'd0;
      disp_min   <= 7'd0;
    end else begin
      clr <= 1'b0;

      // Live tracking everywhere except while frozen in LAP; the RUN->LAP
      // edge itself is a tracking edge, which is what captures the snapshot.
      if (state_r != ST_LAP) begin
        disp_ms  <= ms;
        disp_sec <= sec;
        disp_min <= min;
      end

      if (ovf_set_s) begin
        ovf <= 1'b1;
      end

      case (state_r)
        ST_IDLE: begin
          if (ev_ss_s) begin
            state_r <= ST_RUN;
            run_en  <= 1'b1;
          end else if (ev_lr_s) begin
            clr <= 1'b1;
            ovf <= 1'b0;
          end
        end
        ST_RUN: begin
          if (ev_ss_s) begin
            state_r <= ST_PAUSE;
            run_en  <= 1'b0;
          end else if (ev_lr_s) begin
            state_r    <= ST_LAP;
            lap_active <= 1'b1;
          end
        end
        ST_LAP: begin
          if (ev_ss_s) begin
            state_r    <= ST_PAUSE;
            run_en     <= 1'b0;
            lap_active <= 1'b0;
          end else if (ev_lr_s) begin
            state_r    <= ST_RUN;
            lap_active <= 1'b0;
          end
        end
        ST_PAUSE: begin
          if (ev_ss_s) begin
            state_r <= ST_RUN;
            run_en  <= 1'b1;
          end else if (ev_lr_s) begin
            state_r <= ST_IDLE;
            clr     <= 1'b1;
            ovf     <= 1'b0;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          run_en     <= 1'b0;
          lap_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a 4-cycle debounce.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_ss;
  logic       btn_lr;
  logic [6:0] ms;
  logic [6:0] sec;
  logic [6:0] min;
  logic       tick_s;
  logic       run_en;
  logic       clr;
  logic [6:0] disp_ms;
  logic [6:0] disp_sec;
  logic [6:0] disp_min;
  logic       lap_active;
  logic       ovf;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic  ss;
    logic  lr;
    logic  exp_run;
    logic  exp_lap;
    logic  exp_clr;
    string name;
  } vec_t;

  vec_t tbl [13];

  stopwatch_ctrl #(.DEB_CYCLES(4), .DEB_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_ss     (btn_ss),
    .btn_lr     (btn_lr),
    .ms         (ms),
    .sec        (sec),
    .min        (min),
    .tick_s     (tick_s),
    .run_en     (run_en),
    .clr        (clr),
    .disp_ms    (disp_ms),
    .disp_sec   (disp_sec),
    .disp_min   (disp_min),
    .lap_active (lap_active),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_disp(input string name, input int e_ms, input int e_sec, input int e_min);
    chk({name, ".ms"},  {25'd0, disp_ms},  e_ms);
    chk({name, ".sec"}, {25'd0, disp_sec}, e_sec);
    chk({name, ".min"}, {25'd0, disp_min}, e_min);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raise the chosen buttons and wait sync(2)+debounce(4)+event(1)+state(1) edges.
  task automatic press(input logic ss, input logic lr);
    btn_ss = ss;
    btn_lr = lr;
    step(8);
  endtask

  task automatic release_all();
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    step(10);
  endtask

  // clr must never coincide with run_en.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      if (clr === 1'b1 && run_en === 1'b1) begin
        failures++;
        $display("FAIL clr_while_run: got clr=1 run_en=1 expected clr=0");
      end
    end
  end

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "run->pause"};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "pause->idle_clr"};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "idle_clr"};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "idle->run"};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "run->lap"};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "lap->run"};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "run->lap2"};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "lap->pause"};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "pause->run"};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "both->pause"};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "pause->run2"};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "run->pause2"};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "pause->idle2"};

    // Reset with both buttons held and non-zero timer inputs.
    rst    = 1'b1;
    btn_ss = 1'b1;
    btn_lr = 1'b1;
    tick_s = 1'b0;
    ms     = 7'd11;
    sec    = 7'd22;
    min    = 7'd33;
    step(3);
    chk("rst.run_en", run_en, 0);
    chk("rst.clr", clr, 0);
    chk("rst.lap", lap_active, 0);
    chk("rst.ovf", ovf, 0);
    chk_disp("rst.disp", 0, 0, 0);

    // Held buttons after reset: simultaneous events, start/stop wins -> RUN.
    rst = 1'b0;
    step(7);
    chk("post_rst.early_run", run_en, 0);
    step(1);
    chk("post_rst.run_en", run_en, 1);
    chk("post_rst.lap", lap_active, 0);
    chk("post_rst.clr", clr, 0);
    chk_disp("post_rst.disp", 11, 22, 33);
    release_all();

    // Transition table, starting in RUN.
    for (int i = 0; i < 13; i++) begin
      press(tbl[i].ss, tbl[i].lr);
      chk({tbl[i].name, ".run_en"}, run_en, tbl[i].exp_run);
      chk({tbl[i].name, ".lap"}, lap_active, tbl[i].exp_lap);
      chk({tbl[i].name, ".clr"}, clr, tbl[i].exp_clr);
      step(1);
      chk({tbl[i].name, ".clr_next"}, clr, 0);
      release_all();
      chk({tbl[i].name, ".held_run"}, run_en, tbl[i].exp_run);
    end

    // Bounce rejection from IDLE: pulses of 1, 2, 3 cycles then a steady press.
    btn_ss = 1'b1; step(1);
    btn_ss = 1'b0; step(1);
    btn_ss = 1'b1; step(2);
    btn_ss = 1'b0; step(2);
    btn_ss = 1'b1; step(3);
    btn_ss = 1'b0; step(3);
    btn_ss = 1'b1;
    step(7);
    chk("bounce.early", run_en, 0);
    step(1);
    chk("bounce.run_en", run_en, 1);
    step(2);
    btn_ss = 1'b0;
    step(10);
    chk("bounce.single_event", run_en, 1);

    // Lap freeze in RUN.
    ms  = 7'd42;
    sec = 7'd17;
    min = 7'd3;
    press(1'b0, 1'b1);
    chk("lap.active", lap_active, 1);
    chk_disp("lap.capture", 42, 17, 3);
    ms  = 7'd50;
    sec = 7'd20;
    min = 7'd4;
    step(3);
    chk_disp("lap.frozen", 42, 17, 3);
    btn_lr = 1'b0;
    step(10);
    chk_disp("lap.frozen2", 42, 17, 3);
    ms  = 7'd60;
    sec = 7'd30;
    min = 7'd5;
    press(1'b0, 1'b1);
    chk("unlap.lap", lap_active, 0);
    chk("unlap.run_en", run_en, 1);
    chk_disp("unlap.edge", 42, 17, 3);
    step(1);
    chk_disp("unlap.live", 60, 30, 5);
    ms  = 7'd61;
    sec = 7'd31;
    min = 7'd6;
    step(1);
    chk_disp("unlap.latency", 61, 31, 6);
    release_all();

    // Overflow: needs both sec and min at 59.
    sec    = 7'd59;
    min    = 7'd58;
    tick_s = 1'b1;
    step(1);
    tick_s = 1'b0;
    chk("ovf.min58", ovf, 0);
    min    = 7'd59;
    tick_s = 1'b1;
    step(1);
    tick_s = 1'b0;
    chk("ovf.set", ovf, 1);
    step(3);
    chk("ovf.sticky", ovf, 1);
    press(1'b1, 1'b0);
    chk("ovf.pause_run", run_en, 0);
    chk("ovf.pause", ovf, 1);
    release_all();
    chk("ovf.pause_held", ovf, 1);
    tick_s = 1'b1;
    press(1'b0, 1'b1);
    chk("ovf.clr_cycle.clr", clr, 1);
    chk("ovf.clr_cycle.ovf", ovf, 0);
    step(1);
    chk("ovf.after_clr.clr", clr, 0);
    chk("ovf.tick_in_clr", ovf, 0);
    step(2);
    chk("ovf.idle_tick", ovf, 0);
    tick_s = 1'b0;
    release_all();
    chk("ovf.final_idle_run", run_en, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
